pkt_buf: RTL and testbench
==========================

// Module: pkt_buf
// PURPOSE
//  Packet store-and-forward buffer directly downstream of the head/tail detector.
//  Consumes its 9-bit word stream: [7:0] is the byte, [8] is set on the last byte of a packet.
//  Makes only complete packets readable via a valid/ready read port.
//  Drops oversize packets, and packets that overflow the buffer, as whole packets.
// PARAMETERS
//  DEPTH    256  buffer words, power of 2
//  ADDR_W   8    log2(DEPTH)
//  MAX_LEN  64   max bytes per packet incl. tail; longer packets are dropped
// PORTS
//  i_clk             in   1   single clock
//  i_rst             in   1   asynchronous, active-high reset
//  iv_data           in   9   [8]=tail flag, [7:0]=byte
//  i_data_wr         in   1   iv_data valid this cycle; no backpressure upstream
//  ov_data           out  8   read byte
//  o_data_valid      out  1   ov_data valid
//  o_data_last       out  1   ov_data is last byte of packet
//  i_data_ready      in   1   consumer accepts when valid&ready
//  o_pkt_avail       out  1   >=1 committed packet not yet fully read
//  ov_pkt_cnt        out  ADDR_W+1  committed packets in buffer
//  o_drop            out  1   1-cycle pulse when a packet is discarded
//  ov_drop_cnt       out  16  dropped packets, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset: all outputs 0; pointers, counters and FSM cleared. A partial packet is lost.
//  After reset the next written word starts a new packet.
//  Memory: DEPTH x 9, synchronous write and synchronous read; bit 8 stores the tail flag.
//  Write pointers: wr_ptr (speculative) and cm_ptr (committed); reads never pass cm_ptr.
//  Write FSM:
//   ACCEPT: each write stores at wr_ptr, increments wr_ptr and len.
//    Write with tail=1: cm_ptr<=wr_ptr+1, pkt_cnt+1, len<=0; stay in ACCEPT.
//    Full or len==MAX_LEN with tail=0: wr_ptr<=cm_ptr, o_drop pulses, drop_cnt+1.
//     The word is not stored; go to DISCARD.
//    Full = wr_ptr+1==rd_ptr (modulo DEPTH), so one slot is always kept free.
//    A packet whose tail is word MAX_LEN is accepted.
//   DISCARD: writes are ignored until a write with tail=1, then go to ACCEPT (len=0).
//   A tail-flag write hitting full also drops the packet and stays in ACCEPT.
//  Read side:
//   First-word-fall-through output register; fetch from rd_ptr while rd_ptr!=cm_ptr.
//   The register is empty or being accepted this cycle.
//   Idle buffer: o_data_valid rises exactly 2 cycles after the tail write cycle.
//   ov_data and o_data_last stay stable while valid&!ready.
//   Sustained ready gives 1 byte/cycle, with no bubble between packets.
//   Accepting a word with last=1 decrements pkt_cnt.
//  pkt_cnt increment and decrement in the same cycle leaves it unchanged.
//  o_pkt_avail = (pkt_cnt!=0).
//  Pointer arithmetic wraps modulo DEPTH, with no special case at the wrap.
//  A drop never disturbs committed data or the read port.
// TESTING
//  1. 4-byte pkt 11,22,33,44(tail), ready=1
//     -> valid 2 cyc after tail; 11,22,33,44 out; last only on 44; pkt_cnt 1->0.
//  2. 3 back-to-back 10-byte pkts, ready=0 then 1
//     -> pkt_cnt=3; 30 bytes out contiguously; 3 last pulses.
//  3. 65-byte pkt (MAX_LEN=64) then 2-byte pkt
//     -> o_drop at byte 65, drop_cnt=1; only the 2-byte pkt readable.
//  4. ready=0, write 300 bytes as 5x60-byte pkts
//     -> pkts 1-4 committed (240 words); pkt 5 dropped when full; drop_cnt=1.
//  5. Drain, then write over the wrap with ready toggling 1010
//     -> data intact across address 255->0; valid/ov_data held while not ready.
//  6. Reset mid-packet and mid-read
//     -> all outputs 0; next 2-byte pkt readable 2 cyc after its tail.

Source files
------------

// File: rtl/pkt_buf.sv
// Store-and-forward packet buffer: accepts a tail-flagged byte stream and exposes
// only complete packets on a first-word-fall-through valid/ready read port.
module pkt_buf #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned MAX_LEN = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [8:0]        iv_data,
  input  logic              i_data_wr,
  output logic [7:0]        ov_data,
  output logic              o_data_valid,
  output logic              o_data_last,
  input  logic              i_data_ready,
  output logic              o_pkt_avail,
  output logic [ADDR_W:0]   ov_pkt_cnt,
  output logic              o_drop,
  output logic [15:0]       ov_drop_cnt
);

  localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1);
  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned WORD_W = 9;

  typedef enum logic {
    S_ACCEPT,
    S_DISCARD
  } wr_state_e;

  logic [WORD_W-1:0] mem_q [DEPTH];

  wr_state_e         state_q,   state_d;
  logic [ADDR_W-1:0] wr_ptr_q,  wr_ptr_d;
  logic [ADDR_W-1:0] cm_ptr_q,  cm_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q,  rd_ptr_d;
  logic [LEN_W-1:0]  len_q,     len_d;
  logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;
  logic              drop_q,    drop_d;
  logic              avail_q,   avail_d;
  logic              valid_q,   valid_d;
  logic [WORD_W-1:0] data_q;

  logic              mem_we_c;
  logic              commit_c;
  logic              full_c;
  logic              pop_c;
  logic              fetch_c;
  logic              tail_c;

  // Write FSM, commit/drop bookkeeping and read-side fetch control.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    cm_ptr_d   = cm_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    len_d      = len_q;
    pkt_cnt_d  = pkt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    drop_d     = 1'b0;
    valid_d    = valid_q;
    mem_we_c   = 1'b0;
    commit_c   = 1'b0;
    tail_c     = iv_data[8];
    // One slot stays free so wr_ptr never catches rd_ptr from behind.
    full_c     = ((wr_ptr_q + ADDR_W'(1)) == rd_ptr_q);

    unique case (state_q)
      S_ACCEPT: begin
        if (i_data_wr) begin
          if (full_c || (len_q == LEN_W'(MAX_LEN))) begin
            // Rewind the speculative pointer; the whole packet disappears.
            wr_ptr_d = cm_ptr_q;
            len_d    = '0;
            drop_d   = 1'b1;
            if (drop_cnt_q != 16'hFFFF) begin
              drop_cnt_d = drop_cnt_q + 16'd1;
            end
            state_d = tail_c ? S_ACCEPT : S_DISCARD;
          end else begin
            mem_we_c = 1'b1;
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            if (tail_c) begin
              cm_ptr_d = wr_ptr_q + ADDR_W'(1);
              commit_c = 1'b1;
              len_d    = '0;
            end else begin
              len_d = len_q + LEN_W'(1);
            end
          end
        end
      end
      S_DISCARD: begin
        len_d = '0;
        if (i_data_wr && tail_c) begin
          state_d = S_ACCEPT;
        end
      end
      default: state_d = S_ACCEPT;
    endcase

    // Output register refills whenever it is empty or being consumed.
    pop_c   = valid_q && i_data_ready;
    fetch_c = (rd_ptr_q != cm_ptr_q) && (!valid_q || i_data_ready);
    if (fetch_c) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      valid_d  = 1'b1;
    end else if (pop_c) begin
      valid_d = 1'b0;
    end

    unique case ({commit_c, pop_c && data_q[8]})
      2'b10:   pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
      2'b01:   pkt_cnt_d = pkt_cnt_q - CNT_W'(1);
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
    avail_d = (pkt_cnt_d != '0);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_ACCEPT;
      wr_ptr_q   <= '0;
      cm_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      len_q      <= '0;
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
      drop_q     <= 1'b0;
      avail_q    <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      cm_ptr_q   <= cm_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      len_q      <= len_d;
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      drop_q     <= drop_d;
      avail_q    <= avail_d;
      valid_q    <= valid_d;
    end
  end

  // Buffer storage; bit 8 carries the tail flag.
  always_ff @(posedge i_clk) begin
    if (mem_we_c) begin
      mem_q[wr_ptr_q] <= iv_data;
    end
  end

  // Synchronous read straight into the output register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      data_q <= '0;
    end else if (fetch_c) begin
      data_q <= mem_q[rd_ptr_q];
    end
  end

  assign ov_data      = data_q[7:0];
  assign o_data_last  = data_q[8];
  assign o_data_valid = valid_q;
  assign o_pkt_avail  = avail_q;
  assign ov_pkt_cnt   = pkt_cnt_q;
  assign o_drop       = drop_q;
  assign ov_drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_pkt_buf.sv
// Directed and randomized bench for pkt_buf against a packet-queue reference model.
module tb_pkt_buf;

  localparam int unsigned DEPTH   = 256;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned MAX_LEN = 64;

  logic              clk = 1'b0;
  logic              i_rst;
  logic [8:0]        iv_data;
  logic              i_data_wr;
  logic [7:0]        ov_data;
  logic              o_data_valid;
  logic              o_data_last;
  logic              i_data_ready;
  logic              o_pkt_avail;
  logic [ADDR_W:0]   ov_pkt_cnt;
  logic              o_drop;
  logic [15:0]       ov_drop_cnt;

  pkt_buf #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .MAX_LEN(MAX_LEN)) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .iv_data      (iv_data),
    .i_data_wr    (i_data_wr),
    .ov_data      (ov_data),
    .o_data_valid (o_data_valid),
    .o_data_last  (o_data_last),
    .i_data_ready (i_data_ready),
    .o_pkt_avail  (o_pkt_avail),
    .ov_pkt_cnt   (ov_pkt_cnt),
    .o_drop       (o_drop),
    .ov_drop_cnt  (ov_drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: expected read stream of {last, byte}, and capture from the port.
  logic [8:0] exp_q[$];
  logic [8:0] cap_q[$];
  int cap_base = 0;
  int exp_drop_total = 0;
  int rdy_mode = 0;

  int drop_pulses = 0;
  int last_pulses = 0;
  int stab_err = 0;
  logic hold_prev = 1'b0;
  logic [8:0] prev_word = '0;

  // Port monitor: record accepted words, drop pulses and hold violations.
  always @(negedge clk) begin
    if (i_rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev && !(o_data_valid && ({o_data_last, ov_data} == prev_word)))
        stab_err++;
      hold_prev = o_data_valid && !i_data_ready;
      prev_word = {o_data_last, ov_data};
      if (o_data_valid && i_data_ready) begin
        cap_q.push_back({o_data_last, ov_data});
        if (o_data_last) last_pulses++;
      end
      if (o_drop) drop_pulses++;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_mode == 1) i_data_ready = ~i_data_ready;
    else if (rdy_mode == 2) i_data_ready = 1'($urandom);
  endtask

  task automatic wr_word(input logic [7:0] b, input logic tail);
    i_data_wr = 1'b1;
    iv_data   = {tail, b};
    tick();
    i_data_wr = 1'b0;
  endtask

  task automatic send_pkt(input int len, input bit keep);
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      wr_word(b, i == len - 1);
      if (keep) exp_q.push_back({i == len - 1, b});
    end
  endtask

  task automatic drain();
    int n;
    rdy_mode = 0;
    i_data_ready = 1'b1;
    n = 0;
    while ((ov_pkt_cnt != '0 || o_data_valid) && n < 3000) begin
      tick();
      n++;
    end
    check("drain_done", 32'(n < 3000), 32'd1);
  endtask

  task automatic cmp_stream(input string tag);
    int ncap;
    ncap = cap_q.size() - cap_base;
    check({tag, "_len"}, 32'(ncap), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < ncap; i++)
      check({tag, "_word"}, 32'(cap_q[cap_base + i]), 32'(exp_q[i]));
    cap_base = cap_q.size();
    exp_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_data"},  32'(ov_data), 32'd0);
    check({tag, "_valid"}, 32'(o_data_valid), 32'd0);
    check({tag, "_last"},  32'(o_data_last), 32'd0);
    check({tag, "_avail"}, 32'(o_pkt_avail), 32'd0);
    check({tag, "_pcnt"},  32'(ov_pkt_cnt), 32'd0);
    check({tag, "_drop"},  32'(o_drop), 32'd0);
    check({tag, "_dcnt"},  32'(ov_drop_cnt), 32'd0);
  endtask

  initial begin
    int stored, nv, l0, d0, n, len;
    bit keep;
    i_rst = 1'b1; i_data_wr = 1'b0; iv_data = '0; i_data_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    i_rst = 1'b0;
    tick();

    // 1: single 4-byte packet, latency and ordering
    i_data_ready = 1'b1;
    wr_word(8'h11, 1'b0); exp_q.push_back({1'b0, 8'h11});
    wr_word(8'h22, 1'b0); exp_q.push_back({1'b0, 8'h22});
    wr_word(8'h33, 1'b0); exp_q.push_back({1'b0, 8'h33});
    wr_word(8'h44, 1'b1); exp_q.push_back({1'b1, 8'h44});
    check("t1_valid_cyc1", 32'(o_data_valid), 32'd0);
    check("t1_pkt_cnt", 32'(ov_pkt_cnt), 32'd1);
    check("t1_avail", 32'(o_pkt_avail), 32'd1);
    tick();
    check("t1_valid_cyc2", 32'(o_data_valid), 32'd1);
    check("t1_first", 32'(ov_data), 32'h11);
    drain();
    cmp_stream("t1");
    check("t1_pkt_cnt_end", 32'(ov_pkt_cnt), 32'd0);
    check("t1_avail_end", 32'(o_pkt_avail), 32'd0);

    // 2: three back-to-back packets held, then streamed contiguously
    i_data_ready = 1'b0;
    for (int p = 0; p < 3; p++) send_pkt(10, 1'b1);
    repeat (3) tick();
    check("t2_pkt_cnt", 32'(ov_pkt_cnt), 32'd3);
    check("t2_valid_held", 32'(o_data_valid), 32'd1);
    l0 = last_pulses;
    i_data_ready = 1'b1;
    nv = 0;
    for (int i = 0; i < 30; i++) begin
      if (o_data_valid) nv++;
      tick();
    end
    check("t2_contig", 32'(nv), 32'd30);
    check("t2_valid_after", 32'(o_data_valid), 32'd0);
    check("t2_lasts", 32'(last_pulses - l0), 32'd3);
    check("t2_pkt_cnt_end", 32'(ov_pkt_cnt), 32'd0);
    cmp_stream("t2");

    // 3: oversize drop, then a short packet and a maximum-length packet
    d0 = drop_pulses;
    send_pkt(65, 1'b0);
    exp_drop_total++;
    check("t3_drop_pulse", 32'(o_drop), 32'd1);
    tick();
    check("t3_drop_single", 32'(o_drop), 32'd0);
    check("t3_drop_cnt", 32'(ov_drop_cnt), 32'(exp_drop_total));
    check("t3_no_pkt", 32'(ov_pkt_cnt), 32'd0);
    send_pkt(2, 1'b1);
    send_pkt(64, 1'b1);
    drain();
    cmp_stream("t3");
    check("t3_drop_pulses", 32'(drop_pulses - d0), 32'd1);

    // 4: overflow with reader stalled; capacity is DEPTH-1 stored words plus the output register
    i_data_ready = 1'b0;
    d0 = drop_pulses;
    stored = 0;
    for (int p = 0; p < 5; p++) begin
      keep = (stored + 60 <= int'(DEPTH));
      if (keep) stored += 60;
      else exp_drop_total++;
      send_pkt(60, keep);
    end
    repeat (2) tick();
    check("t4_pkt_cnt", 32'(ov_pkt_cnt), 32'd4);
    check("t4_drop_cnt", 32'(ov_drop_cnt), 32'(exp_drop_total));
    check("t4_drop_pulses", 32'(drop_pulses - d0), 32'd1);
    drain();
    cmp_stream("t4");

    // 5: write across the address wrap with ready toggling every cycle
    rdy_mode = 1;
    i_data_ready = 1'b1;
    for (int p = 0; p < 5; p++) send_pkt(50, 1'b1);
    drain();
    cmp_stream("t5");
    check("t5_hold", 32'(stab_err), 32'd0);

    // Randomized lengths (including oversize) with random backpressure
    d0 = drop_pulses;
    n = exp_drop_total;
    for (int r = 0; r < 12; r++) begin
      rdy_mode = 2;
      for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
        len = int'($urandom_range(1, 72));
        keep = (len <= int'(MAX_LEN));
        if (!keep) exp_drop_total++;
        send_pkt(len, keep);
      end
      drain();
    end
    cmp_stream("rand");
    check("rand_drop_cnt", 32'(ov_drop_cnt), 32'(exp_drop_total));
    check("rand_drop_pulses", 32'(drop_pulses - d0), 32'(exp_drop_total - n));
    check("rand_hold", 32'(stab_err), 32'd0);

    // 6: reset mid-packet and mid-read
    rdy_mode = 0;
    i_data_ready = 1'b0;
    send_pkt(5, 1'b1);
    repeat (3) tick();
    check("t6_valid_pre", 32'(o_data_valid), 32'd1);
    wr_word(8'hA1, 1'b0);
    wr_word(8'hA2, 1'b0);
    #2;
    i_rst = 1'b1;
    #1;
    check_outputs_zero("t6_rst");
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    exp_q.delete();
    cap_base = cap_q.size();
    exp_drop_total = 0;
    i_data_ready = 1'b1;
    tick();
    send_pkt(2, 1'b1);
    check("t6_valid_cyc1", 32'(o_data_valid), 32'd0);
    tick();
    check("t6_valid_cyc2", 32'(o_data_valid), 32'd1);
    drain();
    cmp_stream("t6");
    check("t6_drop_cnt", 32'(ov_drop_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
